// File: rtl/plot_framebuffer.sv
// plot_framebuffer
//   Sink end of the processor plot interface. Pixel writes (x, y, color_draw)
//   strobed by plot land in an on-chip WIDTH x HEIGHT x 3-bit frame store.
//   A free-running raster scanner reads the store and emits a timed pixel
//   stream with blanking flags. The store is cleared to BG_COLOR after reset
//   and whenever clear is pulsed while running.
// Ports
//   clk, reset        single rising-edge clock, synchronous active-high reset
//   x, y, color_draw  plot coordinates and color
//   plot              write strobe, one pixel per asserted cycle
//   clear             request a full clear (honoured only while running)
//   busy              high while clearing; plots are dropped meanwhile
//   drop_count        saturating count of dropped plots
//   pix_color         scanned pixel color (0 in blanking or while clearing)
//   pix_strobe        one-cycle pulse marking a new scanned slot
//   hblank, vblank    blanking flags of the current slot
//   frame_start       pulses with the strobe of pixel (0,0)
module plot_framebuffer #(
  parameter int         WIDTH    = 160,
  parameter int         HEIGHT   = 120,
  parameter int         PIX_DIV  = 4,
  parameter int         H_BLANK  = 40,
  parameter int         V_BLANK  = 10,
  parameter logic [2:0] BG_COLOR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [2:0] color_draw,
  input  logic       plot,
  input  logic       clear,
  output logic       busy,
  output logic [7:0] drop_count,
  output logic [2:0] pix_color,
  output logic       pix_strobe,
  output logic       hblank,
  output logic       vblank,
  output logic       frame_start
);

  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int ADDR_W = $clog2(PIXELS);
  localparam int H_TOT  = WIDTH + H_BLANK;
  localparam int V_TOT  = HEIGHT + V_BLANK;
  localparam int H_W    = $clog2(H_TOT);
  localparam int V_W    = $clog2(V_TOT);
  localparam int DIV_W  = $clog2(PIX_DIV);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_addr;
  logic [2:0]        mem [PIXELS];

  logic              in_range;
  logic              plot_drop;
  logic              we;
  logic [ADDR_W-1:0] plot_addr;
  logic [ADDR_W-1:0] wa;
  logic [2:0]        wd;

  logic [DIV_W-1:0]  div;
  logic [H_W-1:0]    h;
  logic [V_W-1:0]    v;
  logic              tick;
  logic              active_scan;
  logic [ADDR_W-1:0] ra;

  logic [2:0]        rd_p1;
  logic              vld_p1;
  logic              hblank_p1;
  logic              vblank_p1;
  logic              fs_p1;
  logic              run_p1;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  assign in_range  = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
  assign plot_addr = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);

  // Single write port: the clear sweep owns it while clearing, plots otherwise.
  // A clear request in the same cycle as a plot wins and drops the plot.
  always_comb begin
    we        = 1'b0;
    wa        = plot_addr;
    wd        = color_draw;
    plot_drop = 1'b0;
    if (state == ST_CLEAR) begin
      we        = 1'b1;
      wa        = clr_addr;
      wd        = BG_COLOR;
      plot_drop = plot;
    end else if (clear) begin
      plot_drop = plot;
    end else if (plot) begin
      if (in_range) we = 1'b1;
      else          plot_drop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_CLEAR;
      clr_addr   <= '0;
      drop_count <= 8'd0;
    end else begin
      if (plot_drop) drop_count <= sat_inc(drop_count);
      case (state)
        ST_CLEAR: begin
          if (clr_addr == ADDR_W'(PIXELS - 1)) begin
            state    <= ST_RUN;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        default: begin
          if (clear) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end
        end
      endcase
    end
  end

  assign busy = (state == ST_CLEAR);

  // Raster scanner: one slot every PIX_DIV cycles, blank slots included.
  assign tick        = (div == DIV_W'(PIX_DIV - 1));
  assign active_scan = (32'(h) < WIDTH) && (32'(v) < HEIGHT);
  assign ra          = active_scan ? (ADDR_W'(v) * ADDR_W'(WIDTH) + ADDR_W'(h)) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= tick ? '0 : div + DIV_W'(1);
      if (tick) begin
        if (h == H_W'(H_TOT - 1)) begin
          h <= '0;
          v <= (v == V_W'(V_TOT - 1)) ? '0 : v + V_W'(1);
        end else begin
          h <= h + H_W'(1);
        end
      end
    end
  end

  // Stage p1: store read and slot flags for the slot ticked in the prior cycle.
  // Read-before-write ordering gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (we)   mem[wa] <= wd;
    if (tick) rd_p1   <= mem[ra];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      fs_p1     <= 1'b0;
      hblank_p1 <= 1'b0;
      vblank_p1 <= 1'b0;
      run_p1    <= 1'b0;
    end else begin
      vld_p1 <= tick;
      fs_p1  <= tick && (h == '0) && (v == '0);
      if (tick) begin
        hblank_p1 <= (32'(h) >= WIDTH);
        vblank_p1 <= (32'(v) >= HEIGHT);
        run_p1    <= (state == ST_RUN);
      end
    end
  end

  // rd_p1 and the gating flags only change on a tick, so the color holds.
  assign pix_color   = (run_p1 && !hblank_p1 && !vblank_p1) ? rd_p1 : 3'b000;
  assign pix_strobe  = vld_p1;
  assign hblank      = hblank_p1;
  assign vblank      = vblank_p1;
  assign frame_start = fs_p1;

endmodule
